// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enum, result record and the reference ALU function.
// Pure combinational helpers, no state; imported by the lockstep checker and its failure log.
package alu_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [2:0] {
        ADD   = 3'd0,
        SUB   = 3'd1,
        AND   = 3'd2,
        OR    = 3'd3,
        XOR   = 3'd4,
        NOT   = 3'd5,
        SHL   = 3'd6,
        PASSB = 3'd7
    } opc_e;

    typedef struct packed {
        logic [ALU_W-1:0] w;
        logic             zer;
        logic             neg;
    } alu_res_t;

    function automatic alu_res_t alu_golden(opc_e opc, logic [ALU_W-1:0] a, logic [ALU_W-1:0] b, logic c);
        alu_res_t         r;
        logic [ALU_W-1:0] cw;
        cw = {{(ALU_W-1){1'b0}}, c};
        case (opc)
            ADD:     r.w = a + b + cw;
            SUB:     r.w = a - b - cw;
            AND:     r.w = a & b;
            OR:      r.w = a | b;
            XOR:     r.w = a ^ b;
            NOT:     r.w = ~a;
            SHL:     r.w = {a[ALU_W-2:0], c};
            default: r.w = b;
        endcase
        r.zer = (r.w == '0);
        r.neg = r.w[ALU_W-1];
        return r;
    endfunction

endpackage

// File: rtl/alu_fail_log.sv
// Holds the first unacknowledged failing operation; capture lands on the same edge as the check.
// No backpressure: later fails while a record is held are dropped unless acked in that cycle.
module alu_fail_log
    import alu_pkg::*;
#(
    parameter int NUM_LANES = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 fail,
    input  logic                 log_ack,
    input  logic [2:0]           fail_opc,
    input  logic [ALU_W-1:0]     fail_a,
    input  logic [ALU_W-1:0]     fail_b,
    input  logic                 fail_c,
    input  logic [NUM_LANES-1:0] fail_mask,
    output logic                 log_valid,
    output logic [2:0]           log_opc,
    output logic [ALU_W-1:0]     log_a,
    output logic [ALU_W-1:0]     log_b,
    output logic                 log_c,
    output logic [NUM_LANES-1:0] log_mask
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOGGED = 1'b1
    } log_st_e;

    log_st_e state;
    log_st_e state_nxt;
    logic    capture;

    // An ack arriving with a new fail frees the slot and refills it in one step.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (fail) begin
                    capture   = 1'b1;
                    state_nxt = LOGGED;
                end
            end
            LOGGED: begin
                if (log_ack) begin
                    if (fail) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            state    <= IDLE;
            log_opc  <= '0;
            log_a    <= '0;
            log_b    <= '0;
            log_c    <= 1'b0;
            log_mask <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                log_opc  <= fail_opc;
                log_a    <= fail_a;
                log_b    <= fail_b;
                log_c    <= fail_c;
                log_mask <= fail_mask;
            end else if (state == LOGGED && state_nxt == IDLE) begin
                log_opc  <= '0;
                log_a    <= '0;
                log_b    <= '0;
                log_c    <= 1'b0;
                log_mask <= '0;
            end
        end
    end

    assign log_valid = (state == LOGGED);

endmodule

// File: rtl/alu_lockstep_checker.sv
// Recomputes the golden ALU result and compares NUM_LANES candidate lanes; 2-cycle latency, 1 op/cycle.
// No backpressure except the optional halt, which silently drops in_valid until clr or reset.
module alu_lockstep_checker
    import alu_pkg::*;
#(
    parameter int NUM_LANES   = 3,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    input  logic [2:0]                 opc,
    input  logic [ALU_W-1:0]           a,
    input  logic [ALU_W-1:0]           b,
    input  logic                       c,
    input  logic [ALU_W*NUM_LANES-1:0] lane_w,
    input  logic [NUM_LANES-1:0]       lane_zer,
    input  logic [NUM_LANES-1:0]       lane_neg,
    input  logic                       log_ack,
    input  logic                       clr,
    output logic                       chk_valid,
    output logic                       chk_pass,
    output logic [NUM_LANES-1:0]       chk_fail_mask,
    output logic [ALU_W-1:0]           gold_w,
    output logic [CNT_W-1:0]           err_cnt,
    output logic                       log_valid,
    output logic [2:0]                 log_opc,
    output logic [ALU_W-1:0]           log_a,
    output logic [ALU_W-1:0]           log_b,
    output logic                       log_c,
    output logic [NUM_LANES-1:0]       log_mask,
    output logic                       halted
);

    logic                       s1_vld;
    logic [2:0]                 s1_opc;
    logic [ALU_W-1:0]           s1_a;
    logic [ALU_W-1:0]           s1_b;
    logic                       s1_c;
    logic [ALU_W*NUM_LANES-1:0] s1_lane_w;
    logic [NUM_LANES-1:0]       s1_zer;
    logic [NUM_LANES-1:0]       s1_neg;

    logic                       accept;
    alu_res_t                   gold;
    logic [NUM_LANES-1:0]       mask_nxt;
    logic                       fail;

    assign accept = in_valid && !halted;

    // Stage 1: clr and reset both flush, and an op offered in that cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            s1_vld    <= 1'b0;
            s1_opc    <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_c      <= 1'b0;
            s1_lane_w <= '0;
            s1_zer    <= '0;
            s1_neg    <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_opc    <= opc;
                s1_a      <= a;
                s1_b      <= b;
                s1_c      <= c;
                s1_lane_w <= lane_w;
                s1_zer    <= lane_zer;
                s1_neg    <= lane_neg;
            end
        end
    end

    always_comb begin
        gold     = alu_golden(opc_e'(s1_opc), s1_a, s1_b, s1_c);
        mask_nxt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            mask_nxt[i] = s1_vld && ((s1_lane_w[ALU_W*i +: ALU_W] != gold.w) ||
                                     (s1_zer[i] != gold.zer) ||
                                     (s1_neg[i] != gold.neg));
        end
    end

    assign fail = |mask_nxt;

    // Stage 2: outputs stay zero on idle cycles so downstream can OR them freely.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            chk_valid     <= 1'b0;
            chk_pass      <= 1'b0;
            chk_fail_mask <= '0;
            gold_w        <= '0;
        end else begin
            chk_valid     <= s1_vld;
            chk_pass      <= s1_vld && !fail;
            chk_fail_mask <= mask_nxt;
            gold_w        <= s1_vld ? gold.w : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            err_cnt <= '0;
        end else if (fail && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    // Halt rises together with the failing check, so only the op already in stage 1 still drains.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            halted <= 1'b0;
        end else if (STOP_ON_ERR && fail) begin
            halted <= 1'b1;
        end
    end

    alu_fail_log #(
        .NUM_LANES (NUM_LANES)
    ) u_fail_log (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .fail      (fail),
        .log_ack   (log_ack),
        .fail_opc  (s1_opc),
        .fail_a    (s1_a),
        .fail_b    (s1_b),
        .fail_c    (s1_c),
        .fail_mask (mask_nxt),
        .log_valid (log_valid),
        .log_opc   (log_opc),
        .log_a     (log_a),
        .log_b     (log_b),
        .log_c     (log_c),
        .log_mask  (log_mask)
    );

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// Random + directed bench for two checker instances (4-bit counter free-running, 16-bit counter with halt).
// Scoreboard: issue side pushes expected checks, a negedge monitor pops and compares.
module tb_alu_lockstep_checker;

    localparam int NL = 3;

    typedef struct {
        int          issue;
        logic [2:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [2:0]  mask;
        logic [15:0] gold;
    } exp_t;

    typedef struct packed {
        logic [2:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [2:0]  mask;
    } rec_t;

    typedef struct packed {
        logic        cv;
        logic        pass;
        logic [2:0]  mask;
        logic [15:0] gold;
        logic [15:0] cnt;
        logic        lv;
        logic [2:0]  lopc;
        logic [15:0] la;
        logic [15:0] lb;
        logic        lc;
        logic [2:0]  lmask;
        logic        halted;
    } obs_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    opc = '0;
    logic [15:0]   a = '0;
    logic [15:0]   b = '0;
    logic          c = 1'b0;
    logic [47:0]   lane_w = '0;
    logic [2:0]    lane_zer = '0;
    logic [2:0]    lane_neg = '0;
    logic          log_ack = 1'b0;
    logic          clr = 1'b0;

    logic          a_cv, a_pass, a_lv, a_lc, a_halt;
    logic [2:0]    a_mask, a_lopc, a_lmask;
    logic [15:0]   a_gold, a_la, a_lb;
    logic [3:0]    a_cnt;
    logic          b_cv, b_pass, b_lv, b_lc, b_halt;
    logic [2:0]    b_mask, b_lopc, b_lmask;
    logic [15:0]   b_gold, b_la, b_lb;
    logic [15:0]   b_cnt;

    obs_t          obs [2];

    always #5 clk = ~clk;

    // Instance 0: small counter so saturation is reachable quickly.
    alu_lockstep_checker #(.NUM_LANES(NL), .CNT_W(4), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .opc(opc), .a(a), .b(b), .c(c),
        .lane_w(lane_w), .lane_zer(lane_zer), .lane_neg(lane_neg), .log_ack(log_ack), .clr(clr),
        .chk_valid(a_cv), .chk_pass(a_pass), .chk_fail_mask(a_mask), .gold_w(a_gold), .err_cnt(a_cnt),
        .log_valid(a_lv), .log_opc(a_lopc), .log_a(a_la), .log_b(a_lb), .log_c(a_lc), .log_mask(a_lmask),
        .halted(a_halt));

    alu_lockstep_checker #(.NUM_LANES(NL), .CNT_W(16), .STOP_ON_ERR(1'b1)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .opc(opc), .a(a), .b(b), .c(c),
        .lane_w(lane_w), .lane_zer(lane_zer), .lane_neg(lane_neg), .log_ack(log_ack), .clr(clr),
        .chk_valid(b_cv), .chk_pass(b_pass), .chk_fail_mask(b_mask), .gold_w(b_gold), .err_cnt(b_cnt),
        .log_valid(b_lv), .log_opc(b_lopc), .log_a(b_la), .log_b(b_lb), .log_c(b_lc), .log_mask(b_lmask),
        .halted(b_halt));

    assign obs[0] = {a_cv, a_pass, a_mask, a_gold, 12'd0, a_cnt, a_lv, a_lopc, a_la, a_lb, a_lc, a_lmask, a_halt};
    assign obs[1] = {b_cv, b_pass, b_mask, b_gold, b_cnt, b_lv, b_lopc, b_la, b_lb, b_lc, b_lmask, b_halt};

    // Reference model state
    exp_t          q [2][$];
    int unsigned   m_cnt [2];
    bit            m_halt [2];
    bit            m_logv [2];
    rec_t          m_rec [2];
    bit            rst_q, clr_q, ack_q, seen;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [15:0] ref_gold(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                                             input logic ci);
        int r;
        int xi;
        int yi;
        int cii;
        xi  = int'(x);
        yi  = int'(y);
        cii = int'(ci);
        case (o)
            3'd0:    r = xi + yi + cii;
            3'd1:    r = xi - yi - cii;
            3'd2:    r = xi & yi;
            3'd3:    r = xi | yi;
            3'd4:    r = xi ^ yi;
            3'd5:    r = ~xi;
            3'd6:    r = xi * 2 + cii;
            default: r = yi;
        endcase
        return r[15:0];
    endfunction

    function automatic int unsigned cnt_max(input int k);
        return (k == 0) ? 32'd15 : 32'd65535;
    endfunction

    function automatic exp_t make_exp();
        exp_t        e;
        logic [15:0] g;
        logic [15:0] lw;
        g      = ref_gold(opc, a, b, c);
        e.issue = cyc;
        e.opc  = opc;
        e.a    = a;
        e.b    = b;
        e.c    = c;
        e.gold = g;
        e.mask = '0;
        for (int i = 0; i < NL; i++) begin
            lw = 16'(lane_w >> (16 * i));
            if (lw != g || lane_zer[i] != (g == 16'd0) || lane_neg[i] != g[15]) e.mask[i] = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input int k, input string nm, input logic [79:0] act, input logic [79:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s [dut%0d] cyc=%0d got=%0h want=%0h", nm, k, cyc, act, want);
        end
    endtask

    // Issue side: sees exactly what the DUTs sample at each rising edge.
    initial begin : issue_side
        forever begin
            @(posedge clk);
            cyc++;
            seen  = 1'b1;
            rst_q = rstn;
            clr_q = clr;
            ack_q = log_ack;
            for (int k = 0; k < 2; k++) begin
                if (!rstn || clr) q[k].delete();
                else if (in_valid && !m_halt[k]) q[k].push_back(make_exp());
            end
        end
    end

    initial begin : monitor
        obs_t o;
        exp_t e;
        bit   fl;
        bit   want;
        forever begin
            @(negedge clk);
            if (seen) begin
                for (int k = 0; k < 2; k++) begin
                    o  = obs[k];
                    fl = 1'b0;
                    if (!rst_q || clr_q) begin
                        m_cnt[k]  = 0;
                        m_halt[k] = 1'b0;
                        m_logv[k] = 1'b0;
                        if (!rst_q) check(k, "reset_all_zero", 80'(o), 80'd0);
                        else        check(k, "clr_state", 80'({o.cv, o.cnt, o.lv, o.halted}), 80'd0);
                    end else begin
                        want = (q[k].size() != 0) && (q[k][0].issue == cyc - 1);
                        check(k, "chk_valid", 80'(o.cv), 80'(want));
                        if (want) begin
                            e  = q[k].pop_front();
                            fl = (e.mask != 3'd0);
                            check(k, "chk_pass", 80'(o.pass), 80'(!fl));
                            check(k, "chk_fail_mask", 80'(o.mask), 80'(e.mask));
                            check(k, "gold_w", 80'(o.gold), 80'(e.gold));
                        end else begin
                            check(k, "idle_pass_mask", 80'({o.pass, o.mask}), 80'd0);
                        end
                        if (fl && m_cnt[k] < cnt_max(k)) m_cnt[k]++;
                        if (fl && k == 1) m_halt[k] = 1'b1;
                        if (m_logv[k] && ack_q) begin
                            if (fl) m_rec[k] = {e.opc, e.a, e.b, e.c, e.mask};
                            else    m_logv[k] = 1'b0;
                        end else if (!m_logv[k] && fl) begin
                            m_logv[k] = 1'b1;
                            m_rec[k]  = {e.opc, e.a, e.b, e.c, e.mask};
                        end
                        check(k, "err_cnt", 80'(o.cnt), 80'(m_cnt[k]));
                        check(k, "log_valid", 80'(o.lv), 80'(m_logv[k]));
                        check(k, "halted", 80'(o.halted), 80'(m_halt[k]));
                        if (m_logv[k])
                            check(k, "log_record", 80'({o.lopc, o.la, o.lb, o.lc, o.lmask}), 80'(m_rec[k]));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        log_ack  = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic set_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic [2:0] bad);
        logic [15:0] g;
        logic [15:0] lw;
        logic        lz;
        logic        ln;
        g        = ref_gold(o, x, y, ci);
        in_valid = 1'b1;
        opc      = o;
        a        = x;
        b        = y;
        c        = ci;
        for (int i = 0; i < NL; i++) begin
            lw = g;
            lz = (g == 16'd0);
            ln = g[15];
            if (bad[i]) begin
                case ($urandom_range(2))
                    0:       lw = lw ^ 16'(32'd1 << $urandom_range(15));
                    1:       lz = ~lz;
                    default: ln = ~ln;
                endcase
            end
            lane_w[16*i +: 16] = lw;
            lane_zer[i]        = lz;
            lane_neg[i]        = ln;
        end
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rnd_op(input logic [2:0] bad);
        set_op(3'($urandom_range(7)), rnd16(), rnd16(), 1'($urandom_range(1)), bad);
    endtask

    function automatic logic [2:0] rnd_bad();
        logic [2:0] m;
        for (int i = 0; i < NL; i++) m[i] = ($urandom_range(7) == 0);
        return m;
    endfunction

    initial begin : stimulus
        repeat (3) step();
        rstn = 1'b1;
        step();

        // Wrapping ADD with all lanes correct, then SUB with lane 1 wrong.
        set_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 3'b000);
        step();
        set_op(3'd1, 16'h0000, 16'h0001, 1'b0, 3'b000);
        lane_w[31:16] = 16'h0000;
        step();
        repeat (3) step();

        // Back-to-back fails, then an ack coinciding with a third fail.
        clr = 1'b1;
        step();
        rnd_op(3'b001);
        step();
        rnd_op(3'b100);
        step();
        repeat (2) step();
        rnd_op(3'b010);
        step();
        log_ack = 1'b1;
        step();
        step();
        log_ack = 1'b1;
        step();
        log_ack = 1'b1;
        step();

        // Halting instance: one fail followed by four good ops.
        clr = 1'b1;
        step();
        rnd_op(3'b111);
        step();
        repeat (4) begin
            rnd_op(3'b000);
            step();
        end
        repeat (3) step();
        clr = 1'b1;
        step();
        repeat (2) step();

        // Counter saturation on the 4-bit instance.
        clr = 1'b1;
        step();
        repeat (14) begin
            rnd_op(3'b001);
            step();
        end
        repeat (2) step();
        repeat (3) begin
            rnd_op(3'b010);
            step();
        end
        repeat (3) step();

        // Reset with ops in flight.
        rnd_op(3'b000);
        step();
        rnd_op(3'b000);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        repeat (2) step();

        for (int n = 0; n < 3000; n++) begin
            rstn = 1'b1;
            if ($urandom_range(3) != 0) rnd_op(rnd_bad());
            if ($urandom_range(9) == 0) log_ack = 1'b1;
            if ($urandom_range(96) == 0) clr = 1'b1;
            if ($urandom_range(198) == 0) rstn = 1'b0;
            step();
        end
        rstn = 1'b1;
        repeat (4) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check(k, "drain_empty", 80'(q[k].size()), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
